// File: rtl/irst_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : irst_sweep_ctrl_pkg
// Brief  : Shared state encodings, key defaults and LFSR helper for the sweep
// Rev    : 1.0
// ============================================================================
package irst_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_COMMIT = 3'd4
    } irst_state_t;

    localparam logic [15:0] IRST_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] IRST_RESET_KEY = 16'h0000;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic [15:0] taps);
        return {1'b0, s[15:1]} ^ (s[0] ? taps : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irst_sweep_ctrl_key_step.sv
`default_nettype none
// ============================================================================
// Module : irst_key_step
// Brief  : One Galois LFSR step of a seed; a zero seed is replaced by 1
// Rev    : 1.0
// ============================================================================
module irst_key_step
    import irst_sweep_ctrl_pkg::*;
#(
    parameter logic [15:0] LFSR_TAPS = IRST_LFSR_TAPS
) (
    input  logic [15:0] seed,
    output logic [15:0] key_next
);

    logic [15:0] w_seed;

    // An all-zero state would make the LFSR stick at zero forever.
    assign w_seed   = (seed == 16'h0000) ? 16'h0001 : seed;
    assign key_next = lfsr_step(w_seed, LFSR_TAPS);

endmodule
`default_nettype wire

// File: rtl/irst_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : irst_sweep_ctrl
// Brief  : Stalls the core and re-keys every instruction word, then commits key
// Rev    : 1.0
// ============================================================================
module irst_sweep_ctrl
    import irst_sweep_ctrl_pkg::*;
#(
    parameter int          PC_WIDTH  = 8,
    parameter int          DEPTH     = 256,
    parameter logic [15:0] LFSR_TAPS = IRST_LFSR_TAPS,
    parameter logic [15:0] RESET_KEY = IRST_RESET_KEY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [15:0]         seed,
    input  logic                hold_ack,
    output logic                hold_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_rd_data,
    output logic                imem_wr_en,
    output logic [15:0]         imem_wr_data,
    output logic [15:0]         key_out,
    output logic                busy,
    output logic                done
);

    localparam logic [PC_WIDTH-1:0] c_LAST_ADDR = PC_WIDTH'(DEPTH - 1);

    irst_state_t r_state;
    logic [15:0] r_key_cur;
    logic [15:0] r_key_next;
    logic [15:0] w_step;

    irst_key_step #(
        .LFSR_TAPS (LFSR_TAPS)
    ) u_key_step (
        .seed     (seed),
        .key_next (w_step)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_key_cur  <= RESET_KEY;
            r_key_next <= RESET_KEY;
            hold_req   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            imem_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_key_next <= w_step;
                        busy       <= 1'b1;
                        hold_req   <= 1'b1;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_ack) begin
                        imem_addr <= '0;
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (hold_ack) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Losing the ack mid-write re-reads so the data is fresh on resume.
                    if (!hold_ack) begin
                        r_state <= ST_READ;
                    end else if (imem_addr == c_LAST_ADDR) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        imem_addr <= imem_addr + PC_WIDTH'(1);
                        r_state   <= ST_READ;
                    end
                end
                ST_COMMIT: begin
                    r_key_cur <= r_key_next;
                    done      <= 1'b1;
                    hold_req  <= 1'b0;
                    busy      <= 1'b0;
                    imem_addr <= '0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read data only arrives in the WRITE cycle, so the write path is combinational.
    assign imem_wr_en   = (r_state == ST_WRITE) && hold_ack;
    assign imem_wr_data = imem_wr_en ? (imem_rd_data ^ r_key_cur ^ r_key_next) : 16'h0000;
    assign key_out      = r_key_cur;

endmodule
`default_nettype wire

// File: tb/tb_irst_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_irst_sweep_ctrl
// Brief  : Directed bench with a word-level re-keying model and memory model
// Rev    : 1.0
// ============================================================================
module tb_irst_sweep_ctrl;

    localparam int PCW = 8;
    localparam int D   = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [15:0]    seed = 16'h0000;
    logic           hold_ack = 1'b0;
    logic           hold_req;
    logic [PCW-1:0] imem_addr;
    logic [15:0]    imem_rd_data;
    logic           imem_wr_en;
    logic [15:0]    imem_wr_data;
    logic [15:0]    key_out;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    irst_sweep_ctrl #(
        .PC_WIDTH (PCW),
        .DEPTH    (D)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .hold_ack     (hold_ack),
        .hold_req     (hold_req),
        .imem_addr    (imem_addr),
        .imem_rd_data (imem_rd_data),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_data (imem_wr_data),
        .key_out      (key_out),
        .busy         (busy),
        .done         (done)
    );

    // Synchronous-read instruction memory
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (imem_wr_en) mem[imem_addr] <= imem_wr_data;
        imem_rd_data <= mem[imem_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word-level model: a sweep is the list of (addr, old^kc^kn) writes
    logic [15:0] gold [0:255];
    logic [15:0] m_kc = 16'h0000;
    logic [15:0] m_kn = 16'h0000;
    bit          m_idle = 1'b1;
    bit          m_live = 1'b0;
    bit          m_rst_edge = 1'b0;
    int          q_addr [$];
    logic [15:0] q_data [$];

    function automatic logic [15:0] model_key(input logic [15:0] s);
        logic [15:0] v;
        v = (s == 16'h0000) ? 16'h0001 : s;
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk) begin
        m_rst_edge = !rst;
        if (!rst) begin
            m_live = 1'b1;
            m_idle = 1'b1;
            m_kc   = 16'h0000;
            m_kn   = 16'h0000;
            q_addr.delete();
            q_data.delete();
        end else if (m_live && m_idle && start) begin
            m_kn   = model_key(seed);
            m_idle = 1'b0;
            for (int i = 0; i < D; i++) begin
                q_addr.push_back(i);
                q_data.push_back(gold[i] ^ m_kc ^ m_kn);
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            if (m_rst_edge) begin
                chk("rst_addr", 32'(imem_addr), 32'd0);
                chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
                chk("rst_wr_data", 32'(imem_wr_data), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
            end
            if (done) begin
                chk("done_in_sweep", 32'(!m_idle), 32'd1);
                chk("done_all_written", 32'(q_addr.size()), 32'd0);
                m_kc   = m_kn;
                m_idle = 1'b1;
            end
            chk("key_out", 32'(key_out), 32'(m_kc));
            chk("busy", 32'(busy), 32'(!m_idle));
            chk("hold_req", 32'(hold_req), 32'(!m_idle));
            if (imem_wr_en) begin
                chk("wr_needs_ack", 32'(hold_ack), 32'd1);
                chk("wr_expected", 32'(q_addr.size() != 0), 32'd1);
                if (q_addr.size() != 0) begin
                    chk("wr_addr", 32'(imem_addr), 32'(q_addr[0]));
                    chk("wr_data", 32'(imem_wr_data), 32'(q_data[0]));
                    gold[q_addr[0]] = q_data[0];
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
            end
        end
    end

    // Called right after a clock edge; counts edges from acceptance until done
    task automatic run_sweep(input logic [15:0] sd, input int drop_at, input int drop_len,
                             input int extra_at, output int cyc);
        seed  = sd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
            if (drop_at > 0 && cyc == drop_at) hold_ack = 1'b0;
            if (drop_at > 0 && cyc == drop_at + drop_len) hold_ack = 1'b1;
            if (cyc == extra_at) begin
                start = 1'b1;
                seed  = 16'h1234;
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 200);
        chk("sweep_finished", 32'(cyc < 200), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_image(input string tag);
        chk({tag, "_mem0"}, 32'(mem[0]), 32'h0000A634);
        chk({tag, "_mem1"}, 32'(mem[1]), 32'h0000B400);
        chk({tag, "_mem2"}, 32'(mem[2]), 32'h00004BFF);
        chk({tag, "_mem3"}, 32'(mem[3]), 32'h0000B4B4);
        chk({tag, "_mem4_untouched"}, 32'(mem[4]), 32'h00000000);
    endtask

    int c;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 16'h0000;
            gold[i] = 16'h0000;
        end
        mem[0] = 16'h1234; gold[0] = 16'h1234;
        mem[1] = 16'h0000; gold[1] = 16'h0000;
        mem[2] = 16'hFFFF; gold[2] = 16'hFFFF;
        mem[3] = 16'h00B4; gold[3] = 16'h00B4;

        // Reset held with start asserted
        rst   = 1'b0;
        start = 1'b1;
        seed  = 16'h5555;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_hold_req", 32'(hold_req), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_key_out", 32'(key_out), 32'h0);
        rst      = 1'b1;
        start    = 1'b0;
        hold_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("t1_idle_after_release", 32'(busy), 32'd0);

        // Basic sweep
        run_sweep(16'h0001, 0, 0, 0, c);
        chk("t2_done_latency", 32'(c), 32'd10);
        chk("t2_key_out", 32'(key_out), 32'h0000B400);
        chk_image("t2");

        // Same key again: words rewritten unchanged
        run_sweep(16'h0001, 0, 0, 0, c);
        chk("t3_done_latency", 32'(c), 32'd10);
        chk("t3_key_out", 32'(key_out), 32'h0000B400);
        chk_image("t3");

        // Zero seed behaves as seed 1
        run_sweep(16'h0000, 0, 0, 0, c);
        chk("t4_key_out", 32'(key_out), 32'h0000B400);
        chk_image("t4");

        // Ack dropped for 3 cycles while writing addr 2
        run_sweep(16'h0001, 6, 3, 0, c);
        chk("t5_done_latency", 32'(c), 32'd14);
        chk("t5_key_out", 32'(key_out), 32'h0000B400);
        chk_image("t5");

        // Second start mid-sweep is ignored
        run_sweep(16'h0001, 0, 0, 3, c);
        chk("t6_done_latency", 32'(c), 32'd10);
        chk("t6_key_out", 32'(key_out), 32'h0000B400);
        chk_image("t6");

        // Reset while addr 1 is being read
        seed  = 16'h0003;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6r_addr_before_rst", 32'(imem_addr), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("t6r_hold_req", 32'(hold_req), 32'd0);
        chk("t6r_key_out", 32'(key_out), 32'h0);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("t6r_mem0_rekeyed", 32'(mem[0]), 32'h0000A635);
        chk("t6r_mem1_untouched", 32'(mem[1]), 32'h0000B400);
        chk("t6r_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
